// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake with operand and result bus
interface serial_subtractor_if #(parameter int n_bit = 4);
  logic             start;
  logic [n_bit-1:0] A;
  logic [n_bit-1:0] B;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [n_bit-1:0] diff_res;
  logic             b_out;
  modport master(output start, A, B, b_in, input busy, done, diff_res, b_out);
  modport slave(input start, A, B, b_in, output busy, done, diff_res, b_out);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - b_in, LSB first, one full-subtractor cell and a borrow flop
module serial_subtractor #(
  parameter int n_bit = 4
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave io
);
  localparam int cw = $clog2(n_bit);
  localparam logic [cw-1:0] last = cw'(n_bit - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [n_bit-1:0] a_q, a_d, b_q, b_d, w_q, w_d, diff_q, diff_d;
  logic             br_q, br_d, bo_q, bo_d, d, nb;
  logic [cw-1:0]    cnt_q, cnt_d;
  assign d  = a_q[0] ^ b_q[0] ^ br_q;
  assign nb = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    unique case (state_q)
      IDLE: if (io.start) begin
        a_d     = io.A;
        b_d     = io.B;
        br_d    = io.b_in;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = nb;
        w_d   = {d, w_q[n_bit-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == last) begin
          diff_d  = w_d;
          bo_d    = nb;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
    end
  end
  assign io.busy     = state_q != IDLE;
  assign io.done     = state_q == DONE;
  assign io.diff_res = diff_q;
  assign io.b_out    = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks on a 4-bit instance plus random ops on an 8-bit instance
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  serial_subtractor_if #(.n_bit(4)) if4 ();
  serial_subtractor_if #(.n_bit(8)) if8 ();
  serial_subtractor #(.n_bit(4)) dut4 (.clk(clk), .rst_n(rst_n), .io(if4));
  serial_subtractor #(.n_bit(8)) dut8 (.clk(clk), .rst_n(rst_n), .io(if8));
  always #5 clk = ~clk;
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin, output int lat);
    @(negedge clk);
    if4.A = a;
    if4.B = b;
    if4.b_in = bin;
    if4.start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) if4.start = 1'b0;
      if (if4.done) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, output int lat);
    @(negedge clk);
    if8.A = a;
    if8.B = b;
    if8.b_in = bin;
    if8.start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) if8.start = 1'b0;
      if (if8.done) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({if4.busy, if4.done, if4.diff_res, if4.b_out} !== 7'b0)
      begin bad++; $display("FAIL reset4: got busy=%b done=%b diff=%h bo=%b, want all 0", if4.busy, if4.done, if4.diff_res, if4.b_out); end
    total++;
    if ({if8.busy, if8.done, if8.diff_res, if8.b_out} !== 11'b0)
      begin bad++; $display("FAIL reset8: got busy=%b done=%b diff=%h bo=%b, want all 0", if8.busy, if8.done, if8.diff_res, if8.b_out); end
    rst_n = 1'b1;
  endtask
  task automatic test_basic;
    logic [3:0] va [6] = '{4'd7, 4'd3, 4'd0, 4'd0, 4'hF, 4'd5};
    logic [3:0] vb [6] = '{4'd3, 4'd7, 4'd0, 4'hF, 4'd0, 4'd5};
    logic       vi [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] ed [6] = '{4'd4, 4'hC, 4'hF, 4'd1, 4'hF, 4'hF};
    logic       eb [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int lat;
    for (int k = 0; k < 6; k++) begin
      op4(va[k], vb[k], vi[k], lat);
      total++;
      if (lat !== 5 || if4.busy !== 1'b1)
        begin bad++; $display("FAIL basic%0d_timing: got lat=%0d busy=%b, want lat=5 busy=1", k, lat, if4.busy); end
      total++;
      if (if4.diff_res !== ed[k] || if4.b_out !== eb[k])
        begin bad++; $display("FAIL basic%0d_result: got diff=%h bo=%b, want diff=%h bo=%b", k, if4.diff_res, if4.b_out, ed[k], eb[k]); end
    end
    @(negedge clk);
    total++;
    if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.diff_res !== 4'hF || if4.b_out !== 1'b1)
      begin bad++; $display("FAIL basic_hold: got done=%b busy=%b diff=%h bo=%b, want 0 0 f 1", if4.done, if4.busy, if4.diff_res, if4.b_out); end
  endtask
  task automatic test_hold_start;
    int pulses = 0;
    int lat = -1;
    @(negedge clk);
    if4.A = 4'd9;
    if4.B = 4'd2;
    if4.b_in = 1'b0;
    if4.start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) if4.A = 4'd1;
      if (if4.done) pulses++;
    end
    total++;
    if (pulses !== 1)
      begin bad++; $display("FAIL hold_pulses: got %0d done pulses, want 1", pulses); end
    total++;
    if (if4.done !== 1'b1 || if4.diff_res !== 4'd7 || if4.b_out !== 1'b0)
      begin bad++; $display("FAIL hold_result: got done=%b diff=%h bo=%b, want 1 7 0", if4.done, if4.diff_res, if4.b_out); end
    @(negedge clk);
    total++;
    if (if4.busy !== 1'b0 || if4.diff_res !== 4'd7)
      begin bad++; $display("FAIL hold_idle: got busy=%b diff=%h, want busy=0 diff=7", if4.busy, if4.diff_res); end
    @(negedge clk);
    if4.start = 1'b0;
    total++;
    if (if4.busy !== 1'b1 || if4.diff_res !== 4'd7)
      begin bad++; $display("FAIL hold_reaccept: got busy=%b diff=%h, want busy=1 diff=7", if4.busy, if4.diff_res); end
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      if (if4.done) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat !== 5 || if4.diff_res !== 4'hF || if4.b_out !== 1'b1)
      begin bad++; $display("FAIL hold_second: got lat=%0d diff=%h bo=%b, want lat=5 diff=f bo=1", lat, if4.diff_res, if4.b_out); end
  endtask
  task automatic test_reset_abort;
    int pulses = 0;
    int lat;
    @(negedge clk);
    if4.A = 4'd5;
    if4.B = 4'd1;
    if4.b_in = 1'b0;
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({if4.busy, if4.done, if4.diff_res, if4.b_out} !== 7'b0)
      begin bad++; $display("FAIL abort_outputs: got busy=%b done=%b diff=%h bo=%b, want all 0", if4.busy, if4.done, if4.diff_res, if4.b_out); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if4.done || if4.busy) pulses++;
    end
    total++;
    if (pulses !== 0)
      begin bad++; $display("FAIL abort_quiet: got %0d cycles with busy/done, want 0", pulses); end
    op4(4'd5, 4'd1, 1'b0, lat);
    total++;
    if (lat !== 5 || if4.diff_res !== 4'd4 || if4.b_out !== 1'b0)
      begin bad++; $display("FAIL abort_rerun: got lat=%0d diff=%h bo=%b, want lat=5 diff=4 bo=0", lat, if4.diff_res, if4.b_out); end
  endtask
  task automatic test_back_to_back;
    logic [3:0] ed [3] = '{4'd1, 4'd6, 4'hC};
    logic       eb [3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] k4;
    int n = 0;
    @(negedge clk);
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) @(negedge clk);
      k4 = 4'(k);
      if (k > 0) begin
        total++;
        if (if4.done !== (k % 6 == 5))
          begin bad++; $display("FAIL b2b_done%0d: got done=%b, want %b", k, if4.done, (k % 6 == 5)); end
        if (k % 6 == 5 && n < 3) begin
          total++;
          if (if4.diff_res !== ed[n] || if4.b_out !== eb[n])
            begin bad++; $display("FAIL b2b_result%0d: got diff=%h bo=%b, want diff=%h bo=%b", n, if4.diff_res, if4.b_out, ed[n], eb[n]); end
          n++;
        end
      end
      if4.A = 4'(3 * k + 1);
      if4.B = 4'(2 * k);
      if4.b_in = k4[2];
      if4.start = 1'b1;
    end
    if4.start = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic test_random8;
    logic [7:0] a, b;
    logic       bin;
    logic [8:0] exp;
    int lat;
    for (int k = 0; k < 1002; k++) begin
      a = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      b = (k == 0) ? 8'hFF : (k == 1) ? 8'h00 : 8'($urandom_range(0, 255));
      bin = (k < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      exp = {1'b0, a} - {1'b0, b} - {8'd0, bin};
      op8(a, b, bin, lat);
      total++;
      if (lat !== 9 || {if8.b_out, if8.diff_res} !== exp)
        begin bad++; $display("FAIL rand8_%0d: %h-%h-%b got lat=%0d bo=%b diff=%h, want lat=9 bo=%b diff=%h", k, a, b, bin, lat, if8.b_out, if8.diff_res, exp[8], exp[7:0]); end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    if4.start = 1'b0;
    if4.A = '0;
    if4.B = '0;
    if4.b_in = 1'b0;
    if8.start = 1'b0;
    if8.A = '0;
    if8.B = '0;
    if8.b_in = 1'b0;
    test_reset;
    test_basic;
    test_hold_start;
    test_reset_abort;
    test_back_to_back;
    test_random8;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
